// File: rtl/pmod_stand_spi_solo_pkg.sv
// Shared types and byte constants for the PmodCLS SPI target and its byte receiver.
package pmod_stand_spi_solo_pkg;

   localparam int unsigned c_line_chars = 16;
   localparam int unsigned c_line_w     = 8 * c_line_chars;
   localparam int unsigned c_col_w      = 5;

   typedef logic [c_line_w-1:0] t_pmod_cls_ascii_line_16;

   typedef enum logic [2:0] {
      ST_TEXT,
      ST_ESC,
      ST_CSI,
      ST_ROW,
      ST_SEMI,
      ST_COL1,
      ST_COL2
   } t_pmod_cls_tgt_state;

   localparam logic [7:0] c_cls_esc   = 8'h1B;
   localparam logic [7:0] c_cls_csi   = 8'h5B;
   localparam logic [7:0] c_cls_clear = 8'h6A;
   localparam logic [7:0] c_cls_home  = 8'h48;
   localparam logic [7:0] c_cls_semi  = 8'h3B;
   localparam logic [7:0] c_cls_space = 8'h20;

   localparam t_pmod_cls_ascii_line_16 c_blank_line = {c_line_chars{c_cls_space}};

   function automatic logic is_printable(input logic [7:0] b);
      return (b >= 8'h20) && (b <= 8'h7E);
   endfunction

   function automatic logic is_digit(input logic [7:0] b);
      return (b >= 8'h30) && (b <= 8'h39);
   endfunction

   // Column 0 lives in the top byte of a line, so the LSB of column c is 8*(15-c).
   function automatic logic [6:0] col_lsb(input logic [3:0] col);
      return {~col, 3'b000};
   endfunction

   // Two-digit column accumulate; anything past 31 saturates, which is out of range anyway.
   function automatic logic [c_col_w-1:0] col_accum(input logic [c_col_w-1:0] tens,
                                                    input logic [3:0]         ones);
      logic [8:0] v;
      v = 9'(tens) * 9'd10 + 9'(ones);
      return (v > 9'd31) ? 5'd31 : v[4:0];
   endfunction

endpackage

// File: rtl/pmod_cls_spi_target_if.sv
// Completed-byte stream from the SPI byte receiver to the command parser.
interface pmod_cls_spi_target_if;
   logic       byte_valid;
   logic [7:0] byte_data;

   modport master (output byte_valid, output byte_data);
   modport slave  (input  byte_valid, input  byte_data);
endinterface

// File: rtl/spi_target_byte_rx.sv
// SPI mode-0 target byte receiver: input synchronizers, SCK edge detect, bit counter, shifter.
// PMOD_CLS_SPI_TARGET_ECHO_EN enables echoing the previously completed byte on CIPO.
module spi_target_byte_rx #(
   parameter int unsigned parm_sync_stages = 2
) (
   input  logic i_clk_40mhz,
   input  logic i_rstn_40mhz,
   input  logic ei_sck,
   input  logic ei_csn,
   input  logic ei_copi,
   output logic eo_cipo_o,
   output logic eo_cipo_t,
   pmod_cls_spi_target_if.master rx_if
);

   localparam int unsigned c_ss = parm_sync_stages;

   logic [c_ss-1:0] sck_sync_q,  sck_sync_d;
   logic [c_ss-1:0] csn_sync_q,  csn_sync_d;
   logic [c_ss-1:0] copi_sync_q, copi_sync_d;
   logic            sck_last_q,  sck_last_d;
   logic            armed_q,     armed_d;
   logic [2:0]      bit_cnt_q,   bit_cnt_d;
   logic [7:0]      shift_q,     shift_d;
   logic            byte_valid_q, byte_valid_d;
   logic [7:0]      byte_data_q,  byte_data_d;

   logic sck_s, csn_s, copi_s, sck_rise_c;

   assign sck_s      = sck_sync_q[c_ss-1];
   assign csn_s      = csn_sync_q[c_ss-1];
   assign copi_s     = copi_sync_q[c_ss-1];
   assign sck_rise_c = sck_s & ~sck_last_q;

   // Bits are only accepted after CSN has been seen high, so a reset released
   // mid-frame waits for the next frame to realign.
   always_comb begin
      sck_sync_d   = {sck_sync_q[c_ss-2:0],  ei_sck};
      csn_sync_d   = {csn_sync_q[c_ss-2:0],  ei_csn};
      copi_sync_d  = {copi_sync_q[c_ss-2:0], ei_copi};
      sck_last_d   = sck_s;
      armed_d      = armed_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      byte_valid_d = 1'b0;
      byte_data_d  = byte_data_q;
      if (csn_s) begin
         bit_cnt_d = 3'd0;
         armed_d   = 1'b1;
      end else if (armed_q && sck_rise_c) begin
         shift_d   = {shift_q[6:0], copi_s};
         bit_cnt_d = bit_cnt_q + 3'd1;
         if (bit_cnt_q == 3'd7) begin
            byte_valid_d = 1'b1;
            byte_data_d  = {shift_q[6:0], copi_s};
         end
      end
   end

   always_ff @(posedge i_clk_40mhz or negedge i_rstn_40mhz) begin
      if (!i_rstn_40mhz) begin
         sck_sync_q   <= '0;
         csn_sync_q   <= '0;
         copi_sync_q  <= '0;
         sck_last_q   <= 1'b0;
         armed_q      <= 1'b0;
         bit_cnt_q    <= 3'd0;
         shift_q      <= 8'h00;
         byte_valid_q <= 1'b0;
         byte_data_q  <= 8'h00;
      end else begin
         sck_sync_q   <= sck_sync_d;
         csn_sync_q   <= csn_sync_d;
         copi_sync_q  <= copi_sync_d;
         sck_last_q   <= sck_last_d;
         armed_q      <= armed_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         byte_valid_q <= byte_valid_d;
         byte_data_q  <= byte_data_d;
      end
   end

   assign rx_if.byte_valid = byte_valid_q;
   assign rx_if.byte_data  = byte_data_q;

`ifdef PMOD_CLS_SPI_TARGET_ECHO_EN
   logic       sck_fall_c;
   logic [7:0] tx_q,     tx_d;
   logic       cipo_t_q, cipo_t_d;

   assign sck_fall_c = ~sck_s & sck_last_q;

   // Idle: preload the last byte; in frame: reload at each byte boundary, else shift.
   always_comb begin
      tx_d     = tx_q;
      cipo_t_d = csn_s | ~armed_q;
      if (csn_s || !armed_q) begin
         tx_d = byte_data_q;
      end else if (sck_fall_c) begin
         tx_d = (bit_cnt_q == 3'd0) ? byte_data_q : {tx_q[6:0], 1'b0};
      end
   end

   always_ff @(posedge i_clk_40mhz or negedge i_rstn_40mhz) begin
      if (!i_rstn_40mhz) begin
         tx_q     <= 8'h00;
         cipo_t_q <= 1'b1;
      end else begin
         tx_q     <= tx_d;
         cipo_t_q <= cipo_t_d;
      end
   end

   assign eo_cipo_o = tx_q[7];
   assign eo_cipo_t = cipo_t_q;
`else
   assign eo_cipo_o = 1'b0;
   assign eo_cipo_t = 1'b1;
`endif

endmodule

// File: rtl/pmod_cls_spi_target.sv
// PmodCLS-style SPI display target: byte receiver plus ESC[ command parser and two 16-char lines.
// PMOD_CLS_SPI_TARGET_ECHO_EN (in the byte receiver) enables CIPO echo.
module pmod_cls_spi_target
   import pmod_stand_spi_solo_pkg::*;
#(
   parameter int unsigned parm_sync_stages = 2
) (
   input  logic                    i_clk_40mhz,
   input  logic                    i_rstn_40mhz,
   input  logic                    ei_sck,
   input  logic                    ei_csn,
   input  logic                    ei_copi,
   output logic                    eo_cipo_o,
   output logic                    eo_cipo_t,
   output logic                    o_byte_valid,
   output logic [7:0]              o_byte_data,
   output t_pmod_cls_ascii_line_16 o_dat_ascii_line1,
   output t_pmod_cls_ascii_line_16 o_dat_ascii_line2,
   output logic                    o_display_cleared,
   output logic                    o_cmd_error,
   output logic                    o_col_overflow
);

   pmod_cls_spi_target_if rx_if ();

   spi_target_byte_rx #(
      .parm_sync_stages (parm_sync_stages)
   ) u_byte_rx (
      .i_clk_40mhz  (i_clk_40mhz),
      .i_rstn_40mhz (i_rstn_40mhz),
      .ei_sck       (ei_sck),
      .ei_csn       (ei_csn),
      .ei_copi      (ei_copi),
      .eo_cipo_o    (eo_cipo_o),
      .eo_cipo_t    (eo_cipo_t),
      .rx_if        (rx_if.master)
   );

   t_pmod_cls_tgt_state     state_q,   state_d;
   logic                    row_q,     row_d;
   logic [c_col_w-1:0]      col_q,     col_d;
   logic                    arg_row_q, arg_row_d;
   logic [c_col_w-1:0]      arg_col_q, arg_col_d;
   logic                    arg_two_q, arg_two_d;
   t_pmod_cls_ascii_line_16 line1_q,   line1_d;
   t_pmod_cls_ascii_line_16 line2_q,   line2_d;
   logic                    cleared_q, cleared_d;
   logic                    err_q,     err_d;
   logic                    ovf_q,     ovf_d;
   logic                    fail_c;
   logic [7:0]              b_c;

   assign b_c = rx_if.byte_data;

   // Parser: advances only on a completed byte; any fault returns to text mode.
   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      col_d     = col_q;
      arg_row_d = arg_row_q;
      arg_col_d = arg_col_q;
      arg_two_d = arg_two_q;
      line1_d   = line1_q;
      line2_d   = line2_q;
      cleared_d = 1'b0;
      err_d     = 1'b0;
      ovf_d     = 1'b0;
      fail_c    = 1'b0;
      if (rx_if.byte_valid) begin
         case (state_q)
            ST_TEXT: begin
               if (b_c == c_cls_esc) begin
                  state_d = ST_ESC;
               end else if (is_printable(b_c)) begin
                  if (!col_q[4]) begin
                     if (row_q) line2_d[col_lsb(col_q[3:0]) +: 8] = b_c;
                     else       line1_d[col_lsb(col_q[3:0]) +: 8] = b_c;
                     col_d = col_q + 5'd1;
                  end else begin
                     ovf_d = 1'b1;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
            ST_ESC: begin
               if (b_c == c_cls_csi) state_d = ST_CSI;
               else                  fail_c  = 1'b1;
            end
            ST_CSI: begin
               if (b_c == c_cls_clear) begin
                  line1_d   = c_blank_line;
                  line2_d   = c_blank_line;
                  row_d     = 1'b0;
                  col_d     = 5'd0;
                  cleared_d = 1'b1;
                  state_d   = ST_TEXT;
               end else if ((b_c == 8'h30) || (b_c == 8'h31)) begin
                  arg_row_d = b_c[0];
                  state_d   = ST_SEMI;
               end else begin
                  fail_c = 1'b1;
               end
            end
            ST_SEMI: begin
               if (b_c == c_cls_semi) state_d = ST_COL1;
               else                   fail_c  = 1'b1;
            end
            ST_COL1: begin
               if (is_digit(b_c)) begin
                  arg_col_d = 5'(b_c[3:0]);
                  arg_two_d = 1'b0;
                  state_d   = ST_COL2;
               end else begin
                  fail_c = 1'b1;
               end
            end
            ST_COL2: begin
               if (b_c == c_cls_home) begin
                  if (arg_col_q > 5'd15) begin
                     fail_c = 1'b1;
                  end else begin
                     row_d   = arg_row_q;
                     col_d   = arg_col_q;
                     state_d = ST_TEXT;
                  end
               end else if (is_digit(b_c) && !arg_two_q) begin
                  arg_col_d = col_accum(arg_col_q, b_c[3:0]);
                  arg_two_d = 1'b1;
               end else begin
                  fail_c = 1'b1;
               end
            end
            default: fail_c = 1'b1;
         endcase
         if (fail_c) begin
            err_d   = 1'b1;
            state_d = ST_TEXT;
         end
      end
   end

   always_ff @(posedge i_clk_40mhz or negedge i_rstn_40mhz) begin
      if (!i_rstn_40mhz) begin
         state_q   <= ST_TEXT;
         row_q     <= 1'b0;
         col_q     <= 5'd0;
         arg_row_q <= 1'b0;
         arg_col_q <= 5'd0;
         arg_two_q <= 1'b0;
         line1_q   <= c_blank_line;
         line2_q   <= c_blank_line;
         cleared_q <= 1'b0;
         err_q     <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         col_q     <= col_d;
         arg_row_q <= arg_row_d;
         arg_col_q <= arg_col_d;
         arg_two_q <= arg_two_d;
         line1_q   <= line1_d;
         line2_q   <= line2_d;
         cleared_q <= cleared_d;
         err_q     <= err_d;
         ovf_q     <= ovf_d;
      end
   end

   assign o_byte_valid      = rx_if.byte_valid;
   assign o_byte_data       = rx_if.byte_data;
   assign o_dat_ascii_line1 = line1_q;
   assign o_dat_ascii_line2 = line2_q;
   assign o_display_cleared = cleared_q;
   assign o_cmd_error       = err_q;
   assign o_col_overflow    = ovf_q;

endmodule
